// File: rtl/os_xor_accum.sv
// XOR accumulator for the OS_XOR2 array: folds ACC_LEN GF(2) partial results
// into one tile and hands completed tiles to a 1-entry valid/ready output register.
//
// state | meaning
// IDLE  | no partial tile; acc and beat_cnt are zero
// ACC   | partial tile in progress; beat_cnt beats already folded into acc
module os_xor_accum #(
    parameter int W       = 7,
    parameter int ACC_LEN = 16,
    parameter int TCNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [W-1:0]      in_y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [W-1:0]      out_acc,
    output logic [TCNT_W-1:0] tile_cnt,
    output logic              busy
);

    localparam int CNT_W = (ACC_LEN > 1) ? $clog2(ACC_LEN) : 1;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(ACC_LEN - 1);

    typedef enum logic {
        IDLE = 1'b0,
        ACC  = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     acc;
    logic [W-1:0]     acc_nxt;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] beat_cnt_nxt;
    logic             last_beat;
    logic             out_full;
    logic             drain;
    logic             accept;
    logic             tile_done;

    assign last_beat = (beat_cnt == LAST_BEAT);
    assign out_full  = out_valid && !out_ready;
    assign drain     = out_valid && out_ready;
    // Only the closing beat has to wait for room in the output register.
    assign in_ready  = rst_n && !flush && !(last_beat && out_full);
    assign accept    = in_valid && in_ready;
    assign tile_done = accept && last_beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // With ACC_LEN==1 the first beat is also the last, so the FSM never leaves IDLE.
    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = IDLE;
        end else if (accept) begin
            state_nxt = last_beat ? IDLE : ACC;
        end
    end

    always_comb begin
        busy         = (state == ACC);
        acc_nxt      = acc;
        beat_cnt_nxt = beat_cnt;
        if (flush) begin
            acc_nxt      = '0;
            beat_cnt_nxt = '0;
        end else if (accept) begin
            if (last_beat) begin
                acc_nxt      = '0;
                beat_cnt_nxt = '0;
            end else begin
                acc_nxt      = acc ^ in_y;
                beat_cnt_nxt = beat_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            beat_cnt <= '0;
        end else begin
            acc      <= acc_nxt;
            beat_cnt <= beat_cnt_nxt;
        end
    end

    // A completing tile wins over a drain in the same cycle, keeping out_valid high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            out_acc   <= '0;
        end else if (tile_done) begin
            out_valid <= 1'b1;
            out_acc   <= acc ^ in_y;
        end else if (drain) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tile_cnt <= '0;
        end else if (drain) begin
            tile_cnt <= tile_cnt + TCNT_W'(1);
        end
    end

endmodule

// File: tb/tb_os_xor_accum.sv
// Scoreboard bench for os_xor_accum: a 16-beat build and a 1-beat build with a
// 4-bit tile counter; expected tiles are queued at stimulus time, popped on drain.
module tb_os_xor_accum;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;

    logic        flush_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [6:0]  in_y_a, out_acc_a;
    logic [15:0] tile_cnt_a;

    logic        flush_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [6:0]  in_y_b, out_acc_b;
    logic [3:0]  tile_cnt_b;

    os_xor_accum #(.W(7), .ACC_LEN(16), .TCNT_W(16)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush_a),
        .in_valid(in_valid_a), .in_ready(in_ready_a), .in_y(in_y_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a), .out_acc(out_acc_a),
        .tile_cnt(tile_cnt_a), .busy(busy_a)
    );

    os_xor_accum #(.W(7), .ACC_LEN(1), .TCNT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush_b),
        .in_valid(in_valid_b), .in_ready(in_ready_b), .in_y(in_y_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b), .out_acc(out_acc_b),
        .tile_cnt(tile_cnt_b), .busy(busy_b)
    );

    int         checks = 0;
    int         errors = 0;
    logic [6:0] qa[$];
    logic [6:0] qb[$];
    int         exp_tiles_a = 0;
    logic [3:0] exp_tiles_b = 4'd0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitors sample mid-cycle: a handshake seen here completes at the next rising edge.
    always @(negedge clk) begin
        if (rst_n && out_valid_a && out_ready_a) begin
            if (qa.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected_tile: got %0h expected no tile", out_acc_a);
            end else begin
                chk("a_out_acc", 32'(out_acc_a), 32'(qa.pop_front()));
            end
            chk("a_tile_cnt", 32'(tile_cnt_a), exp_tiles_a);
            exp_tiles_a++;
        end
    end

    always @(negedge clk) begin
        if (rst_n && out_valid_b && out_ready_b) begin
            if (qb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected_tile: got %0h expected no tile", out_acc_b);
            end else begin
                chk("b_out_acc", 32'(out_acc_b), 32'(qb.pop_front()));
            end
            chk("b_tile_cnt", 32'(tile_cnt_b), 32'(exp_tiles_b));
            exp_tiles_b = exp_tiles_b + 4'd1;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic beat_a(input logic [6:0] y);
        int n = 0;
        in_valid_a = 1'b1;
        in_y_a     = y;
        #1;
        while (!in_ready_a && n < 50) begin
            step();
            n++;
        end
        if (!in_ready_a) begin
            checks++;
            errors++;
            $display("FAIL a_beat_timeout: in_ready got 0 expected 1");
        end
        step();
    endtask

    task automatic tile_a(input logic [6:0] first, input logic [6:0] rest, input logic [6:0] exp);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) qa.push_back(exp);
            beat_a(i == 0 ? first : rest);
        end
        in_valid_a = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation got stuck expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [6:0] y;
        rst_n = 1'b0;
        flush_a = 1'b0; in_valid_a = 1'b0; in_y_a = '0; out_ready_a = 1'b0;
        flush_b = 1'b0; in_valid_b = 1'b0; in_y_b = '0; out_ready_b = 1'b0;
        #3;
        chk("rst_out_valid", 32'(out_valid_a), 0);
        chk("rst_out_acc", 32'(out_acc_a), 0);
        chk("rst_tile_cnt", 32'(tile_cnt_a), 0);
        chk("rst_busy", 32'(busy_a), 0);
        chk("rst_in_ready", 32'(in_ready_a), 0);
        chk("rst_b_in_ready", 32'(in_ready_b), 0);
        step();
        step();
        rst_n = 1'b1;
        step();

        // Beat index 0..15 XORs to zero.
        out_ready_a = 1'b1;
        for (int i = 0; i < 16; i++) begin
            if (i == 15) qa.push_back(7'h00);
            beat_a(7'(i));
            if (i == 0) chk("t1_busy", 32'(busy_a), 1);
        end
        in_valid_a = 1'b0;
        chk("t1_out_valid", 32'(out_valid_a), 1);
        step();
        chk("t1_pulse_end", 32'(out_valid_a), 0);
        chk("t1_tile_cnt", 32'(tile_cnt_a), 1);
        chk("t1_idle", 32'(busy_a), 0);

        tile_a(7'h55, 7'h00, 7'h55);
        tile_a(7'h7F, 7'h7F, 7'h00);
        step();
        step();
        chk("t2_tile_cnt", 32'(tile_cnt_a), 3);

        // Backpressure: final beat of the second tile waits for the drain.
        out_ready_a = 1'b0;
        tile_a(7'h12, 7'h00, 7'h12);
        for (int i = 0; i < 15; i++) beat_a(7'h01);
        in_valid_a = 1'b1;
        in_y_a     = 7'h30;
        #1;
        chk("t3_stall_in_ready", 32'(in_ready_a), 0);
        chk("t3_hold_acc", 32'(out_acc_a), 32'h12);
        step();
        step();
        chk("t3_stall_in_ready2", 32'(in_ready_a), 0);
        chk("t3_hold_acc2", 32'(out_acc_a), 32'h12);
        chk("t3_hold_valid", 32'(out_valid_a), 1);
        chk("t3_busy", 32'(busy_a), 1);
        qa.push_back(7'h31);
        out_ready_a = 1'b1;
        #1;
        chk("t3_release_in_ready", 32'(in_ready_a), 1);
        step();
        in_valid_a = 1'b0;
        chk("t3_valid_stays", 32'(out_valid_a), 1);
        chk("t3_new_acc", 32'(out_acc_a), 32'h31);
        step();
        chk("t3_tile_cnt", 32'(tile_cnt_a), 5);

        // Flush mid-tile with a completed tile still pending.
        out_ready_a = 1'b0;
        tile_a(7'h44, 7'h00, 7'h44);
        for (int i = 0; i < 7; i++) beat_a(7'h7F);
        in_valid_a = 1'b1;
        in_y_a     = 7'h7F;
        flush_a    = 1'b1;
        #1;
        chk("t4_flush_in_ready", 32'(in_ready_a), 0);
        step();
        flush_a    = 1'b0;
        in_valid_a = 1'b0;
        chk("t4_flush_idle", 32'(busy_a), 0);
        chk("t4_pending_acc", 32'(out_acc_a), 32'h44);
        for (int i = 0; i < 15; i++) beat_a(7'h01);
        chk("t4_pending_acc2", 32'(out_acc_a), 32'h44);
        chk("t4_pending_valid", 32'(out_valid_a), 1);
        out_ready_a = 1'b1;
        qa.push_back(7'h00);
        beat_a(7'h01);
        in_valid_a = 1'b0;
        step();
        step();
        chk("t4_tile_cnt", 32'(tile_cnt_a), 7);

        // Async reset at beat 9 with a tile pending.
        out_ready_a = 1'b0;
        tile_a(7'h21, 7'h00, 7'h21);
        for (int i = 0; i < 9; i++) beat_a(7'h05);
        in_valid_a = 1'b1;
        in_y_a     = 7'h05;
        #1;
        rst_n = 1'b0;
        #1;
        chk("t5_out_valid", 32'(out_valid_a), 0);
        chk("t5_out_acc", 32'(out_acc_a), 0);
        chk("t5_tile_cnt", 32'(tile_cnt_a), 0);
        chk("t5_busy", 32'(busy_a), 0);
        chk("t5_in_ready", 32'(in_ready_a), 0);
        qa.delete();
        exp_tiles_a = 0;
        in_valid_a  = 1'b0;
        step();
        rst_n       = 1'b1;
        out_ready_a = 1'b1;
        step();
        beat_a(7'h03);
        for (int i = 0; i < 14; i++) beat_a(7'h00);
        in_valid_a = 1'b0;
        chk("t5_no_early_tile", 32'(out_valid_a), 0);
        chk("t5_busy_resumed", 32'(busy_a), 1);
        qa.push_back(7'h03);
        beat_a(7'h00);
        in_valid_a = 1'b0;
        chk("t5_tile_out", 32'(out_valid_a), 1);
        step();
        step();
        chk("t5_tile_cnt", 32'(tile_cnt_a), 1);

        // Single-beat tiles: 17 tiles wrap a 4-bit counter to 1.
        out_ready_b = 1'b1;
        for (int i = 0; i < 17; i++) begin
            y = 7'($urandom_range(0, 127));
            qb.push_back(y);
            in_valid_b = 1'b1;
            in_y_b     = y;
            #1;
            chk("b_in_ready", 32'(in_ready_b), 1);
            step();
        end
        in_valid_b = 1'b0;
        step();
        step();
        chk("b_tile_cnt_wrap", 32'(tile_cnt_b), 1);
        chk("b_out_valid_end", 32'(out_valid_b), 0);
        chk("b_busy", 32'(busy_b), 0);

        chk("a_queue_empty", qa.size(), 0);
        chk("b_queue_empty", qb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
